// File: rtl/uart_rx_capture_if.sv
// Receive-side bundle for uart_rx_capture: FIFO handshake plus status.
// master = the receiver that produces bytes, slave = the consumer.
interface uart_rx_capture_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
    logic       busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ack, err_clr
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ack, err_clr
    );
endinterface

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote per bit,
// small receive FIFO popped through a valid/ack handshake.
module uart_rx_capture #(
    parameter int clk_freq       = 100000000,
    parameter int uart_baud_rate = 1152000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rxd,
    uart_rx_capture_if.master  rx
);
    localparam int DIV_RAW = clk_freq / (uart_baud_rate * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_sync1;
    logic              r_sync2;
    logic [DW-1:0]     r_div;
    logic [3:0]        r_sc;
    logic [2:0]        r_idx;
    logic              r_s7;
    logic              r_s8;
    logic [7:0]        r_shift;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [AW:0]       r_cnt;
    logic              r_ferr;
    logic              r_ovr;

    logic              w_rxd;
    logic              w_tick;
    logic              w_maj;
    logic              w_dec;
    logic              w_push;
    logic              w_ferr_set;
    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;
    logic              w_ovr_set;

    assign w_rxd      = r_sync2;
    assign w_tick     = (r_div == DW'(DIV - 1));
    assign w_maj      = (r_s7 & r_s8) | (r_s7 & w_rxd) | (r_s8 & w_rxd);
    assign w_dec      = (r_state == S_STOP) && w_tick && (r_sc == 4'd9);
    assign w_push     = w_dec && w_maj;
    assign w_ferr_set = w_dec && !w_maj;

    assign w_valid    = (r_cnt != '0);
    assign w_full     = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_pop      = w_valid && rx.rx_ack;
    assign w_wr       = w_push && (!w_full || w_pop);
    assign w_ovr_set  = w_push && w_full && !w_pop;

    assign rx.rx_data   = w_valid ? r_mem[r_rp] : 8'h00;
    assign rx.rx_valid  = w_valid;
    assign rx.frame_err = r_ferr;
    assign rx.overrun   = r_ovr;
    assign rx.busy      = (r_state != S_IDLE);

    // Two-flop synchroniser, idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running oversample tick divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Receiver next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rxd) w_next = S_START;
            end
            S_START: begin
                if (w_tick && r_sc == 4'd7 && w_rxd) begin
                    w_next = S_IDLE;
                end else if (w_tick && r_sc == 4'd15) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && r_sc == 4'd15 && r_idx == 3'd7) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_dec) w_next = w_maj ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (w_rxd) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Bit-cell position, mid-cell samples and byte assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sc    <= '0;
            r_idx   <= '0;
            r_s7    <= 1'b1;
            r_s8    <= 1'b1;
            r_shift <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_sc <= '0;
            end else if (w_tick) begin
                r_sc <= r_sc + 4'd1;
            end
            if (w_tick && r_sc == 4'd7) r_s7 <= w_rxd;
            if (w_tick && r_sc == 4'd8) r_s8 <= w_rxd;
            if (r_state == S_START) begin
                r_idx <= '0;
            end else if (r_state == S_DATA && w_tick && r_sc == 4'd15) begin
                r_idx <= r_idx + 3'd1;
            end
            if (r_state == S_DATA && w_tick && r_sc == 4'd9) begin
                r_shift[r_idx] <= w_maj;
            end
        end
    end

    // FIFO storage; contents are don't-care while their slot is empty
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= r_shift;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            if (w_wr && !w_pop) begin
                r_cnt <= r_cnt + (AW+1)'(1);
            end else if (!w_wr && w_pop) begin
                r_cnt <= r_cnt - (AW+1)'(1);
            end
        end
    end

    // Sticky error flags; a same-cycle set beats the clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_ferr_set) begin
                r_ferr <= 1'b1;
            end else if (rx.err_clr) begin
                r_ferr <= 1'b0;
            end
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (rx.err_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end
endmodule
